sb_rx_deser_fifo: RTL

- Parametrised sideband serial receiver; successor to the two-clock sideband RX.
- Oversamples the forwarded serial clock and data pins in a single clock domain, deserialises MSG_WIDTH-bit messages LSB-first, enforces the inter-message gap, and buffers messages in a FIFO with a ready/valid output.
- Adds framing-timeout, gap-violation and overflow detection with sticky error flags.
- Sits between the sideband pins and the sideband link-management logic.

---
 rtl/sb_rx_deser_fifo.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/sb_rx_deser_fifo.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sb_rx_deser_fifo
// Sideband serial receiver. The forwarded serial clock and data pins are
// oversampled in the clk_800MHz domain. MSG_WIDTH-bit messages are
// deserialised LSB-first, a mandatory idle gap is enforced after each one,
// and finished messages are queued in a first-word-fall-through FIFO.
//
// Ports
//   clk_800MHz    sampling clock, all logic on posedge
//   reset_n       asynchronous active-low reset
//   enable_i      receiver enable; low forces IDLE and drops a partial word
//   clkPin_i      forwarded serial clock (async), data valid at falling edge
//   dataPin_i     serial data (async)
//   data_o        FIFO head message
//   valid_o       FIFO non-empty
//   ready_i       consumer accepts head when valid_o & ready_i
//   fifo_level_o  occupied slots
//   overflow_o    sticky: message dropped because FIFO was full
//   gap_err_o     sticky: data=1 sampled during the gap
//   frame_err_o   sticky: partial message aborted by timeout
//   clear_err_i   clears the three sticky flags (a same-cycle set wins)
//   state_o       debug view of the receive FSM state
//
// Output handshake: data_o/valid_o form a valid/ready pair. The head entry
// transfers on every cycle where valid_o & ready_i; while valid_o=1 and
// ready_i=0 the head (data_o) does not change.
// ---------------------------------------------------------------------------
module sb_rx_deser_fifo #(
    parameter int MSG_WIDTH   = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_UI      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk_800MHz,
    input  logic                          reset_n,
    input  logic                          enable_i,
    input  logic                          clkPin_i,
    input  logic                          dataPin_i,
    output logic [MSG_WIDTH-1:0]          data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic                          gap_err_o,
    output logic                          frame_err_o,
    input  logic                          clear_err_i,
    output logic [1:0]                    state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MSG_WIDTH);
    localparam int GW = $clog2(GAP_UI + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] BIT_LAST     = CW'(MSG_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_UI - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [AW:0]   LEVEL_FULL   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // ---------------- pin synchronisers and falling-edge strobe -------------
    // Both pins go through chains of equal length so the synced data stays
    // aligned with the synced clock edge that qualifies it.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s, bit_s, strobe;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign bit_s  = data_sync_q[SYNC_STAGES-1];
    assign strobe = clk_prev_q & ~clk_s;

    always_ff @(posedge clk_800MHz or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], clkPin_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], dataPin_i};
            clk_prev_q  <= clk_s;
        end
    end

    // ---------------- receive FSM ----------------
    state_t                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [MSG_WIDTH-1:0]   shift_q, shift_d;
    logic [MSG_WIDTH-1:0]   push_word;
    logic                   push_req, frame_set, gap_set;

    assign push_word = {bit_s, shift_q[MSG_WIDTH-1:1]};
    assign state_o   = state_q;

    always_ff @(posedge clk_800MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            idle_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        idle_cnt_d = '0;
        shift_d    = shift_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        gap_set    = 1'b0;

        if (!enable_i) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RECV;
                    bit_cnt_d = '0;
                end
                ST_RECV: begin
                    if (strobe) begin
                        shift_d = push_word;
                        if (bit_cnt_q == BIT_LAST) begin
                            push_req  = 1'b1;
                            bit_cnt_d = '0;
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end else if (bit_cnt_q != '0) begin
                        // Only a started message can time out.
                        if (idle_cnt_q == TIMEOUT_LAST) begin
                            frame_set = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            idle_cnt_d = idle_cnt_q + TW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (strobe) begin
                        gap_set = bit_s;
                        if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_d = '0;
                            bit_cnt_d = '0;
                            state_d   = ST_RECV;
                        end else begin
                            gap_cnt_d = gap_cnt_q + GW'(1);
                        end
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end
            endcase
        end
    end

    // ---------------- FIFO ----------------
    logic [MSG_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          level_q, level_d;
    logic                 full, pop, push, ovf_set;

    assign valid_o      = (level_q != '0);
    assign full         = (level_q == LEVEL_FULL);
    assign pop          = valid_o & ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted then.
    assign push         = push_req & (~full | pop);
    assign ovf_set      = push_req & full & ~pop;
    assign data_o       = mem_q[rd_ptr_q];
    assign fifo_level_o = level_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_800MHz or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // ---------------- sticky error flags ----------------
    always_ff @(posedge clk_800MHz or negedge reset_n) begin
        if (!reset_n) begin
            overflow_o  <= 1'b0;
            gap_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_set   | (overflow_o  & ~clear_err_i);
            gap_err_o   <= gap_set   | (gap_err_o   & ~clear_err_i);
            frame_err_o <= frame_set | (frame_err_o & ~clear_err_i);
        end
    end

endmodule
